// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default sizing for the instruction fetch unit.
// The TIMEOUT default is only consumed when FETCH_TIMEOUT_EN is defined.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_t;

    localparam int IFU_N       = 9;
    localparam int IFU_TIMEOUT = 15;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// mem_ack watchdog: a down-counter loaded on clear, expired at terminal count zero.
// It is only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr
    import instr_fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = IFU_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Loaded with TIMEOUT-1 so that expiry lands on the TIMEOUT-th waiting cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= W'(TIMEOUT - 1);
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: samples the PC, reads instruction memory and holds the word in ir.
// Build macro FETCH_TIMEOUT_EN adds a mem_ack watchdog with a sticky fetch_fault.
//
// state     | meaning
// IDLE      | no read outstanding; launches a read when ir is empty
// REQ       | mem_rd held with a stable mem_addr, waiting for mem_ack
// WAIT_DROP | fetch was flushed; swallow the outstanding mem_ack
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int N       = IFU_N,
    parameter int TIMEOUT = IFU_TIMEOUT
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         fetch_en,
    input  logic [N-1:0] pc,
    input  logic         flush,
    output logic [N-1:0] mem_addr,
    output logic         mem_rd,
    input  logic [N-1:0] mem_data,
    input  logic         mem_ack,
    output logic [N-1:0] ir,
    output logic         ir_valid,
    input  logic         ir_ready,
    output logic         pc_inc,
    output logic         fetch_fault
);
    fetch_state_t state;
    logic         launch;
    logic         timeout_hit;
    logic         blocked;

    assign launch = (state == IDLE) && fetch_en && !ir_valid && !flush && !blocked;

`ifdef FETCH_TIMEOUT_EN
    logic fault_q;
    logic ctr_en;
    logic ctr_expired;

    assign ctr_en = ((state == REQ) || (state == WAIT_DROP)) && !mem_ack;

    fetch_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .resetn (resetn),
        .clear  (launch),
        .enable (ctr_en),
        .expired(ctr_expired)
    );

    assign timeout_hit = ctr_en && ctr_expired;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fault_q <= 1'b0;
        end else if (timeout_hit) begin
            fault_q <= 1'b1;
        end
    end

    assign blocked     = fault_q;
    assign fetch_fault = fault_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign blocked     = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            ir       <= '0;
            ir_valid <= 1'b0;
            pc_inc   <= 1'b0;
        end else begin
            pc_inc <= 1'b0;
            case (state)
                IDLE: begin
                    // A flush alongside a consume still just drops the stale word.
                    if (flush || (ir_valid && ir_ready)) begin
                        ir_valid <= 1'b0;
                    end
                    if (launch) begin
                        state    <= REQ;
                        mem_addr <= pc;
                        mem_rd   <= 1'b1;
                    end
                end
                REQ: begin
                    if (flush) begin
                        mem_rd <= 1'b0;
                        state  <= mem_ack ? IDLE : WAIT_DROP;
                    end else if (mem_ack) begin
                        ir       <= mem_data;
                        ir_valid <= 1'b1;
                        mem_rd   <= 1'b0;
                        pc_inc   <= 1'b1;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        mem_rd <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WAIT_DROP: begin
                    mem_rd <= 1'b0;
                    if (mem_ack || timeout_hit) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_rd <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
